// File: rtl/lb_pkg.sv
// Shared types and default geometry for the Sobel line-buffer sequencer.
package lb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL0 = 3'd1,
        FILL1 = 3'd2,
        RUN   = 3'd3,
        FLUSH = 3'd4
    } lb_state_e;

    localparam int LB_IMG_WIDTH  = 640;
    localparam int LB_IMG_HEIGHT = 480;
    localparam int LB_COL_W      = 10;
    localparam int LB_ROW_W      = 9;

endpackage

// File: rtl/line_buff_ctrl_if.sv
// Enable/flag bundle between the sequencer (master) and the two cascaded M10K line buffers (slave).
interface line_buff_ctrl_if;

    logic buf_a_wr_en;
    logic buf_a_rd_en;
    logic buf_b_wr_en;
    logic buf_b_rd_en;
    logic buf_a_flag_i;
    logic buf_b_flag_i;

    modport master (
        output buf_a_wr_en, buf_a_rd_en, buf_b_wr_en, buf_b_rd_en,
        input  buf_a_flag_i, buf_b_flag_i
    );

    modport slave (
        input  buf_a_wr_en, buf_a_rd_en, buf_b_wr_en, buf_b_rd_en,
        output buf_a_flag_i, buf_b_flag_i
    );

endinterface

// File: rtl/lb_pos_counter.sv
// Column/row position counter; col doubles as the flush cycle counter when row_en is low.
module lb_pos_counter #(
    parameter int IMG_WIDTH  = lb_pkg::LB_IMG_WIDTH,
    parameter int IMG_HEIGHT = lb_pkg::LB_IMG_HEIGHT,
    parameter int COL_W      = lb_pkg::LB_COL_W,
    parameter int ROW_W      = lb_pkg::LB_ROW_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             step,
    input  logic             row_en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             col_wrap,
    output logic             last_pix
);

    logic col_last;
    logic row_last;

    assign col_last = (col == COL_W'(IMG_WIDTH - 1));
    assign row_last = (row == ROW_W'(IMG_HEIGHT - 1));
    assign col_wrap = step && col_last;
    assign last_pix = col_wrap && row_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (step) begin
            if (col_last) begin
                col <= '0;
                if (row_en) row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_buff_ctrl.sv
// Line-buffer sequencer: keeps buffers A/B one row apart, flags 3x3 windows, drains at end of frame.
// Optional end-of-flush emptiness check enabled by defining LB_CTRL_FLUSH_CHECK_EN.
module line_buff_ctrl
    import lb_pkg::*;
#(
    parameter int IMG_WIDTH  = LB_IMG_WIDTH,
    parameter int IMG_HEIGHT = LB_IMG_HEIGHT,
    parameter int COL_W      = LB_COL_W,
    parameter int ROW_W      = LB_ROW_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sof_i,
    input  logic                    pix_valid_i,
    line_buff_ctrl_if.master        lbuf,
    output logic                    win_valid_o,
    output logic [COL_W-1:0]        col_o,
    output logic [ROW_W-1:0]        row_o,
    output logic                    frame_done_o,
    output logic                    busy_o,
    output logic                    sof_err_o,
    output logic                    sync_err_o
);

    lb_state_e        state, state_nxt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_wrap, last_pix;
    logic             step, clr;
    logic             wr_a, rd_a, wr_b, rd_b;

    // During FLUSH col counts read cycles; the extra frame_done_o cycle is read-free.
    assign step = (state == FLUSH) ? !frame_done_o
                : ((state == FILL0) || (state == FILL1) || (state == RUN)) && pix_valid_i;
    assign clr  = (state == IDLE) && sof_i;

    lb_pos_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT),
        .COL_W     (COL_W),
        .ROW_W     (ROW_W)
    ) u_pos (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .step    (step),
        .row_en  (state != FLUSH),
        .col     (col),
        .row     (row),
        .col_wrap(col_wrap),
        .last_pix(last_pix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (sof_i)        state_nxt = FILL0;
            FILL0:   if (col_wrap)     state_nxt = FILL1;
            FILL1:   if (col_wrap)     state_nxt = RUN;
            RUN:     if (last_pix)     state_nxt = FLUSH;
            FLUSH:   if (frame_done_o) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_a = 1'b0;
        rd_a = 1'b0;
        wr_b = 1'b0;
        rd_b = 1'b0;
        unique case (state)
            FILL0: wr_a = pix_valid_i;
            FILL1: begin
                wr_a = pix_valid_i;
                rd_a = pix_valid_i;
                wr_b = pix_valid_i;
            end
            RUN: begin
                wr_a = pix_valid_i;
                rd_a = pix_valid_i;
                wr_b = pix_valid_i;
                rd_b = pix_valid_i;
            end
            FLUSH: begin
                rd_a = !frame_done_o;
                rd_b = !frame_done_o;
            end
            default: ;
        endcase
    end

    assign lbuf.buf_a_wr_en = wr_a;
    assign lbuf.buf_a_rd_en = rd_a;
    assign lbuf.buf_b_wr_en = wr_b;
    assign lbuf.buf_b_rd_en = rd_b;
    assign busy_o           = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_o  <= 1'b0;
            col_o        <= '0;
            row_o        <= '0;
            frame_done_o <= 1'b0;
            sof_err_o    <= 1'b0;
        end else begin
            win_valid_o  <= 1'b0;
            if ((state == RUN) && pix_valid_i && (col >= COL_W'(2))) begin
                win_valid_o <= 1'b1;
                col_o       <= col - 1'b1;
                row_o       <= row - 1'b1;
            end
            frame_done_o <= (state == FLUSH) && col_wrap;
            sof_err_o    <= sof_i && (state != IDLE);
        end
    end

`ifdef LB_CTRL_FLUSH_CHECK_EN
    // Flags are sampled in the frame_done_o cycle, i.e. after the last flush read has landed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_err_o <= 1'b0;
        else if (frame_done_o && (lbuf.buf_a_flag_i || lbuf.buf_b_flag_i))
            sync_err_o <= 1'b1;
    end
`else
    assign sync_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_line_buff_ctrl.sv
// Bench for line_buff_ctrl: pixel-index reference model, directed frames plus randomized gaps.
module tb_line_buff_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int CW = 10;
    localparam int RW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sof_i;
    logic          pix_valid_i;
    logic          flag_a, flag_b;
    logic          win_valid_o, frame_done_o, busy_o, sof_err_o, sync_err_o;
    logic [CW-1:0] col_o;
    logic [RW-1:0] row_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 taking pixels, 2 flushing, 3 done cycle
    int ph, n, k;
    logic          exp_win, exp_done, exp_serr, exp_sync;
    int            exp_col, exp_row;

    int cnt_wa, cnt_ra, cnt_wb, cnt_rb, cnt_serr;
    int wq[$];

    always #5 clk = ~clk;

    line_buff_ctrl_if bus ();
    assign bus.buf_a_flag_i = flag_a;
    assign bus.buf_b_flag_i = flag_b;

    line_buff_ctrl #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .COL_W     (CW),
        .ROW_W     (RW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sof_i       (sof_i),
        .pix_valid_i (pix_valid_i),
        .lbuf        (bus.master),
        .win_valid_o (win_valid_o),
        .col_o       (col_o),
        .row_o       (row_o),
        .frame_done_o(frame_done_o),
        .busy_o      (busy_o),
        .sof_err_o   (sof_err_o),
        .sync_err_o  (sync_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0; n = 0; k = 0;
        exp_win = 0; exp_done = 0; exp_serr = 0; exp_sync = 0;
        exp_col = 0; exp_row = 0;
    endtask

    task automatic cyc(input logic s, input logic v);
        logic e_wa, e_ra, e_wb, e_rb;
        int r, c;
        @(negedge clk);
        sof_i = s;
        pix_valid_i = v;
        #1;
        e_wa = 0; e_ra = 0; e_wb = 0; e_rb = 0;
        if (ph == 1) begin
            r = n / W;
            e_wa = v;
            e_ra = v && (r >= 1);
            e_wb = v && (r >= 1);
            e_rb = v && (r >= 2);
        end else if (ph == 2) begin
            e_ra = 1;
            e_rb = 1;
        end
        chk("wr_a", bus.buf_a_wr_en, e_wa);
        chk("rd_a", bus.buf_a_rd_en, e_ra);
        chk("wr_b", bus.buf_b_wr_en, e_wb);
        chk("rd_b", bus.buf_b_rd_en, e_rb);
        chk("busy", busy_o, ph != 0);
        chk("win_valid", win_valid_o, exp_win);
        chk("col_o", col_o, exp_col);
        chk("row_o", row_o, exp_row);
        chk("frame_done", frame_done_o, exp_done);
        chk("sof_err", sof_err_o, exp_serr);
        chk("sync_err", sync_err_o, exp_sync);

        cnt_wa += int'(bus.buf_a_wr_en);
        cnt_ra += int'(bus.buf_a_rd_en);
        cnt_wb += int'(bus.buf_b_wr_en);
        cnt_rb += int'(bus.buf_b_rd_en);
        cnt_serr += int'(sof_err_o);
        if (win_valid_o === 1'b1) wq.push_back(int'(col_o) * 1000 + int'(row_o));

        // advance the model across the coming clock edge
        exp_serr = s && (ph != 0);
        exp_win  = 0;
        exp_done = 0;
        case (ph)
            0: if (s) begin ph = 1; n = 0; end
            1: if (v) begin
                r = n / W;
                c = n % W;
                if (r >= 2 && c >= 2) begin
                    exp_win = 1;
                    exp_col = c - 1;
                    exp_row = r - 1;
                end
                n++;
                if (n == W * H) begin ph = 2; k = 0; end
            end
            2: begin
                k++;
                if (k == W) begin ph = 3; exp_done = 1; end
            end
            default: begin
`ifdef LB_CTRL_FLUSH_CHECK_EN
                if (flag_a || flag_b) exp_sync = 1;
`endif
                ph = 0;
            end
        endcase
    endtask

    task automatic clear_tallies();
        cnt_wa = 0; cnt_ra = 0; cnt_wb = 0; cnt_rb = 0; cnt_serr = 0;
        wq.delete();
    endtask

    // mode 0: continuous, 1: alternating valid, 2: random valid
    task automatic run_frame(input int mode, input int sof_at);
        int guard;
        logic v, s;
        clear_tallies();
        cyc(1'b1, 1'b0);
        guard = 0;
        while (ph != 0 && guard < 500) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((guard % 2) == 0) : 1'($urandom_range(0, 1));
            s = (ph == 1) && (n == sof_at) && v;
            cyc(s, v);
            guard++;
        end
        if (guard >= 500) begin
            checks++;
            failures++;
            $error("FAIL frame_timeout: got %0d cycles expected frame end", guard);
        end
        cyc(1'b0, 1'b0);
    endtask

    task automatic check_totals(input string tag);
        chk({tag, "_wr_a_total"}, cnt_wa, W * H);
        chk({tag, "_rd_a_total"}, cnt_ra, W * (H - 1) + W);
        chk({tag, "_wr_b_total"}, cnt_wb, W * (H - 1));
        chk({tag, "_rd_b_total"}, cnt_rb, W * (H - 2) + W);
    endtask

    task automatic check_windows(input string tag);
        int exp_q[4];
        exp_q = '{1001, 2001, 1002, 2002};
        chk({tag, "_win_count"}, wq.size(), (H - 2) * (W - 2));
        for (int i = 0; i < 4; i++)
            chk({tag, "_win_centre"}, (i < wq.size()) ? wq[i] : -1, exp_q[i]);
    endtask

    initial begin
        rst_n = 1'b0;
        sof_i = 1'b0;
        pix_valid_i = 1'b0;
        flag_a = 1'b0;
        flag_b = 1'b0;
        model_reset();
        clear_tallies();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // pix_valid_i is ignored while idle
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);

        run_frame(0, -1);
        check_totals("cont");
        check_windows("cont");
        chk("cont_sof_err_count", cnt_serr, 0);

        run_frame(1, -1);
        check_totals("gap");
        check_windows("gap");

        run_frame(0, 9);
        check_totals("sofmid");
        check_windows("sofmid");
        chk("sofmid_sof_err_count", cnt_serr, 1);

        // asynchronous reset in the middle of the frame at pixel 6
        clear_tallies();
        cyc(1'b1, 1'b0);
        while (ph == 1 && n < 6) cyc(1'b0, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wr_a", bus.buf_a_wr_en, 0);
        chk("rst_rd_a", bus.buf_a_rd_en, 0);
        chk("rst_wr_b", bus.buf_b_wr_en, 0);
        chk("rst_rd_b", bus.buf_b_rd_en, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_win", win_valid_o, 0);
        chk("rst_col", col_o, 0);
        chk("rst_row", row_o, 0);
        chk("rst_done", frame_done_o, 0);
        chk("rst_sof_err", sof_err_o, 0);
        chk("rst_sync", sync_err_o, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(0, -1);
        check_totals("postrst");
        check_windows("postrst");

        // flags left high at the end of flush, then a clean frame
        flag_a = 1'b1;
        flag_b = 1'b1;
        run_frame(0, -1);
        flag_a = 1'b0;
        flag_b = 1'b0;
        cyc(1'b0, 1'b0);
        run_frame(0, -1);

        // reset clears the sticky error
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst2_sync", sync_err_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        flag_a = 1'b0;
        flag_b = 1'b0;
        run_frame(0, -1);
        chk("flags_low_sync", sync_err_o, 0);

        for (int f = 0; f < 4; f++) begin
            flag_a = (f == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            flag_b = 1'b0;
            run_frame(2, (f == 1) ? int'($urandom_range(0, W * H - 1)) : -1);
            check_totals("rand");
            check_windows("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_buff_ctrl.md
Name: line_buff_ctrl

Overview:
- Sequencer for a two-deep cascade of M10K line buffers that feeds the 3x3 Sobel window in the edge-detection path.
- Buffer A takes camera pixels. Buffer B takes A's output; data routing between them is external, and this block drives only the enables.
- Tracks column/row per frame and gates write/read enables so A and B stay exactly one row apart.
- Flags when a full 3x3 window is valid, and drains both buffers at end of frame so the next frame starts aligned.

Parameters:
- IMG_WIDTH, 640, pixels per row (2..1024)
- IMG_HEIGHT, 480, rows per frame (3..512)
- COL_W, 10, column counter width
- ROW_W, 9, row counter width

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset
- sof_i  in  1  start-of-frame pulse
- pix_valid_i  in  1  one pixel accepted this cycle
- buf_a_flag_i  in  1  buffer A non-empty flag
- buf_b_flag_i  in  1  buffer B non-empty flag
- buf_a_wr_en  out  1  write enable, buffer A
- buf_a_rd_en  out  1  read enable, buffer A
- buf_b_wr_en  out  1  write enable, buffer B
- buf_b_rd_en  out  1  read enable, buffer B
- win_valid_o  out  1  3x3 window centred at (col_o,row_o) is valid
- col_o  out  COL_W  window centre column
- row_o  out  ROW_W  window centre row
- frame_done_o  out  1  one-cycle pulse when flush completes
- busy_o  out  1  high in any state except IDLE
- sof_err_o  out  1  one-cycle pulse: sof_i arrived outside IDLE
- sync_err_o  out  1  sticky flush-check failure

Behaviour:
- Interface: one clock `clk`. Reset `rst_n` is asynchronous, active-low.
- Reset values:
  - all enables, win_valid_o, frame_done_o, busy_o, sof_err_o, sync_err_o = 0
  - col_o = 0, row_o = 0
  - state = IDLE
  - internal col/row counters = 0
- Reset mid-frame: the block returns to IDLE immediately. Buffer contents and indices are not recoverable; the system resets the buffers together with this block.
- Enables are combinational from state and pix_valid_i, so each pixel costs exactly one write/read index step per enabled buffer.
- States:
  - IDLE: no enables. pix_valid_i is ignored. sof_i moves to FILL0 and clears the counters.
  - FILL0 (row 0): buf_a_wr_en = pix_valid_i.
  - FILL1 (row 1): buf_a_wr_en = buf_a_rd_en = buf_b_wr_en = pix_valid_i.
  - RUN (rows 2..IMG_HEIGHT-1): all four enables = pix_valid_i.
  - FLUSH: no writes. buf_a_rd_en = buf_b_rd_en = 1 every cycle for IMG_WIDTH cycles, then pulse frame_done_o and go to IDLE.
- Counters:
  - col increments on each accepted pixel.
  - At col == IMG_WIDTH-1, col wraps to 0 and row increments.
  - Row wraps FILL0→FILL1→RUN.
  - Last pixel (row IMG_HEIGHT-1, col IMG_WIDTH-1) moves to FLUSH, reusing col as the flush counter.
  - Counter arithmetic is unsigned, width-truncated; compare against parameter-1 only.
- Window output:
  - win_valid_o is registered and goes high the cycle after an accepted pixel in RUN with col >= 2.
  - col_o and row_o are registered as col-1 and row-1 on that pixel; they hold otherwise.
  - No windows are produced on border rows/columns or during FLUSH.
  - Total windows per frame = (IMG_HEIGHT-2)*(IMG_WIDTH-2).
- sof_i outside IDLE: ignored for state purposes; sof_err_o pulses for one cycle.
- sof_i in the same cycle frame_done_o is asserted: the block is still in FLUSH, so the sof is reported as an error. Upstream must leave at least one idle cycle.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: LB_CTRL_FLUSH_CHECK_EN
- Defined: on the final FLUSH cycle, the block samples buf_a_flag_i and buf_b_flag_i after the last read. If either is still high (buffer not empty), sync_err_o is set. sync_err_o is sticky and is cleared only by rst_n.
- Undefined: sync_err_o is tied 0 and the flag inputs are unused.

Decomposition:
- Package `lb_pkg` holds:
  - state enum: IDLE, FILL0, FILL1, RUN, FLUSH
  - default IMG_WIDTH/IMG_HEIGHT constants
  - counter-width localparams
- Sub-module `lb_pos_counter`: column/row counter with wrap pulses, instantiated once. The FSM and enable decode stay in the top.

Test Plan:
- Directed tests use IMG_WIDTH=4, IMG_HEIGHT=4.
- Reset-and-run frame: sof, then 16 continuous pixels.
  - Rows 0/1/2-3: 4/4/8 wr_a pulses resp.; 0/4/8 rd_a; 0/4/8 wr_b; 0/0/8 rd_b.
  - Then 4 flush cycles, then frame_done_o one cycle later.
- Window count: same frame.
  - Exactly 4 win_valid_o pulses.
  - Centres in order: (1,1), (2,1), (1,2), (2,2).
- Gapped input: pix_valid_i toggled 1,0,1,0 across the whole frame.
  - No enable asserts on invalid cycles.
  - Identical window coordinates to the continuous case.
- sof mid-RUN: assert sof_i at pixel 9.
  - sof_err_o pulses once.
  - State, counters and enables are unaffected; the frame completes normally.
- Async reset at pixel 6: drop rst_n between clock edges.
  - All outputs 0 immediately; busy_o = 0.
  - A following sof starts a clean frame.
- With LB_CTRL_FLUSH_CHECK_EN, flag check at end of flush:
  - Flags held high: sync_err_o = 1 and stays set until rst_n.
  - Flags low: sync_err_o stays 0.
